// File: rtl/bird_pkg.sv
// ---------------------------------------------------------------------------
// bird_pkg
// Shared types and constants for the bird sprite controller:
//   - bird_state_t : life-cycle states of the bird (encoding is visible on
//                    the stateOut debug port, so values are fixed)
//   - EDGE_*       : bit positions inside the bitmap's {Left,Top,Right,Bottom}
//                    HitEdgeCode vector
//   - COORD_W      : width of integer screen coordinates
//   - fpWidth()    : width of the signed fixed-point position/velocity words
//   - edgeMask()   : keeps only the edges that steer vertical motion
// ---------------------------------------------------------------------------
package bird_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FLY     = 3'd1,
    ST_FALL    = 3'd2,
    ST_RESPAWN = 3'd3
  } bird_state_t;

  localparam int EDGE_LEFT   = 3;
  localparam int EDGE_TOP    = 2;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_BOTTOM = 0;

  localparam int COORD_W = 11;

  // Integer part, fraction, plus one sign bit so that upward velocities and
  // intermediate sums never alias into large positive coordinates.
  function automatic int fpWidth(input int fracBits);
    return COORD_W + fracBits + 1;
  endfunction

  // Left/right contacts never change vertical velocity, so they are removed
  // before the bounce decision looks at the latched edge flags.
  function automatic logic [3:0] edgeMask(input logic [3:0] edges);
    return edges & ~(4'(1 << EDGE_LEFT) | 4'(1 << EDGE_RIGHT));
  endfunction

endpackage

// File: rtl/frame_event_latch.sv
// ---------------------------------------------------------------------------
// frame_event_latch
// Accumulates pixel-level collision events over one video frame so the
// frame-rate FSM can act on them at the next frame tick.
// Ports:
//   clk, resetN          : clock, asynchronous active-low reset
//   i_startOfFrame       : frame tick; the accumulated flags are consumed on
//                          this cycle and restart from empty afterwards
//   i_showBird           : collisions count only while the bird is drawn
//   i_shotCollision      : bird/projectile overlap
//   i_borderCollision    : bird/border overlap
//   i_hitEdgeCode        : {Left,Top,Right,Bottom} edge hit by the bitmap
//   o_shotL              : a shot was seen this frame
//   o_edgeL              : OR of all edge codes seen on border contacts
// ---------------------------------------------------------------------------
module frame_event_latch (
  input  logic       clk,
  input  logic       resetN,
  input  logic       i_startOfFrame,
  input  logic       i_showBird,
  input  logic       i_shotCollision,
  input  logic       i_borderCollision,
  input  logic [3:0] i_hitEdgeCode,
  output logic       o_shotL,
  output logic [3:0] o_edgeL
);

  logic       r_shotL;
  logic [3:0] r_edgeL;

  // On the frame tick the old contents are dropped, but an event arriving on
  // that same cycle is still captured so it is acted on at the next tick.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_shotL <= 1'b0;
      r_edgeL <= 4'b0;
    end else begin
      r_shotL <= (i_startOfFrame ? 1'b0 : r_shotL)
               | (i_shotCollision & i_showBird);
      r_edgeL <= (i_startOfFrame ? 4'b0 : r_edgeL)
               | ((i_borderCollision & i_showBird) ? i_hitEdgeCode : 4'b0);
    end
  end

  assign o_shotL = r_shotL;
  assign o_edgeL = r_edgeL;

endmodule

// File: rtl/bird_flight_ctrl.sv
// ---------------------------------------------------------------------------
// bird_flight_ctrl
// Frame-rate controller for one bird sprite: owns its position, visibility
// and life cycle (idle, flying, falling after a shot, hidden respawn wait).
// Position and velocity are signed fixed-point with FP_BITS fraction bits;
// everything updates only on the cycle after startOfFrame.
// Ports:
//   clk, resetN       : clock, asynchronous active-low reset
//   startOfFrame      : one-cycle pulse per video frame
//   enable            : game running; low returns the bird to IDLE at a tick
//   shotCollision     : bird/projectile pixel overlap
//   borderCollision   : bird/border pixel overlap
//   HitEdgeCode       : {Left,Top,Right,Bottom} from the bird bitmap
//   topLeftX/Y        : integer top-left position for the rectangle block
//   showBird          : draw enable for the bitmap
//   birdHit           : one-cycle score pulse when the bird is shot
//   stateOut          : current state encoding (debug)
// ---------------------------------------------------------------------------
module bird_flight_ctrl
  import bird_pkg::*;
#(
  parameter logic [10:0] INIT_X         = 11'd0,
  parameter logic [10:0] INIT_Y         = 11'd120,
  parameter int          SCREEN_WIDTH   = 640,
  parameter int          SCREEN_HEIGHT  = 480,
  parameter int          FP_BITS        = 6,
  parameter int          SPEED_X        = 64,
  parameter int          SPEED_Y        = 32,
  parameter int          FALL_ACCEL     = 16,
  parameter int          RESPAWN_FRAMES = 60
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        enable,
  input  logic        shotCollision,
  input  logic        borderCollision,
  input  logic [3:0]  HitEdgeCode,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        showBird,
  output logic        birdHit,
  output logic [2:0]  stateOut
);

  localparam int W     = fpWidth(FP_BITS);
  localparam int CNT_W = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;

  localparam logic signed [W-1:0] INIT_X_FP = W'({INIT_X, {FP_BITS{1'b0}}});
  localparam logic signed [W-1:0] INIT_Y_FP = W'({INIT_Y, {FP_BITS{1'b0}}});
  localparam logic signed [W-1:0] VX_FP     = W'(SPEED_X);
  localparam logic signed [W-1:0] VY_FP     = W'(SPEED_Y);
  localparam logic signed [W-1:0] ACC_FP    = W'(FALL_ACCEL);
  // Limits are compared in fixed point: pos >= LIMIT<<FP is the same test as
  // floor(pos) >= LIMIT.
  localparam logic signed [W-1:0] XLIM_FP   = W'(SCREEN_WIDTH * (2 ** FP_BITS));
  localparam logic signed [W-1:0] YLIM_FP   = W'(SCREEN_HEIGHT * (2 ** FP_BITS));
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(RESPAWN_FRAMES - 1);

  bird_state_t           r_state;
  logic signed [W-1:0]   r_posX;
  logic signed [W-1:0]   r_posY;
  logic signed [W-1:0]   r_vx;
  logic signed [W-1:0]   r_vy;
  logic [CNT_W-1:0]      r_respCnt;
  logic                  r_showBird;
  logic                  r_birdHit;

  logic                  w_shotL;
  logic [3:0]            w_edgeL;
  logic signed [W-1:0]   w_flyVy;
  logic signed [W-1:0]   w_flyX;
  logic signed [W-1:0]   w_flyY;
  logic signed [W-1:0]   w_fallVy;
  logic signed [W-1:0]   w_fallY;

  frame_event_latch u_eventLatch (
    .clk               (clk),
    .resetN            (resetN),
    .i_startOfFrame    (startOfFrame),
    .i_showBird        (r_showBird),
    .i_shotCollision   (shotCollision),
    .i_borderCollision (borderCollision),
    .i_hitEdgeCode     (HitEdgeCode),
    .o_shotL           (w_shotL),
    .o_edgeL           (w_edgeL)
  );

  // Bounce decision: a lone top contact pushes the bird down, a lone bottom
  // contact pushes it up; touching both at once is ambiguous and keeps vy.
  always_comb begin
    w_flyVy = r_vy;
    case (edgeMask(w_edgeL))
      4'(1 << EDGE_TOP):    w_flyVy = VY_FP;
      4'(1 << EDGE_BOTTOM): w_flyVy = -VY_FP;
      default:              w_flyVy = r_vy;
    endcase
  end

  // The new velocity is applied within the same frame step.
  assign w_flyX   = r_posX + r_vx;
  assign w_flyY   = r_posY + w_flyVy;
  assign w_fallVy = r_vy + ACC_FP;
  assign w_fallY  = r_posY + w_fallVy;

  // Life-cycle FSM and position datapath. All changes happen on frame ticks;
  // birdHit is the only output that returns to 0 on its own.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= ST_IDLE;
      r_posX     <= INIT_X_FP;
      r_posY     <= INIT_Y_FP;
      r_vx       <= '0;
      r_vy       <= '0;
      r_respCnt  <= '0;
      r_showBird <= 1'b0;
      r_birdHit  <= 1'b0;
    end else begin
      r_birdHit <= 1'b0;
      if (startOfFrame) begin
        if (!enable) begin
          r_state    <= ST_IDLE;
          r_posX     <= INIT_X_FP;
          r_posY     <= INIT_Y_FP;
          r_vx       <= '0;
          r_vy       <= '0;
          r_respCnt  <= '0;
          r_showBird <= 1'b0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              r_state    <= ST_FLY;
              r_showBird <= 1'b1;
              r_posX     <= INIT_X_FP;
              r_posY     <= INIT_Y_FP;
              r_vx       <= VX_FP;
              r_vy       <= VY_FP;
            end
            ST_FLY: begin
              // A shot freezes the bird where it is; bounce is discarded.
              if (w_shotL) begin
                r_state   <= ST_FALL;
                r_vx      <= '0;
                r_vy      <= '0;
                r_birdHit <= 1'b1;
              end else begin
                r_vy   <= w_flyVy;
                r_posY <= w_flyY;
                r_posX <= (w_flyX >= XLIM_FP) ? '0 : w_flyX;
              end
            end
            ST_FALL: begin
              r_vy   <= w_fallVy;
              r_posY <= w_fallY;
              if (w_fallY >= YLIM_FP) begin
                r_state    <= ST_RESPAWN;
                r_showBird <= 1'b0;
                r_respCnt  <= '0;
              end
            end
            ST_RESPAWN: begin
              if (r_respCnt == CNT_LAST) begin
                r_state    <= ST_FLY;
                r_showBird <= 1'b1;
                r_posX     <= INIT_X_FP;
                r_posY     <= INIT_Y_FP;
                r_vx       <= VX_FP;
                r_vy       <= VY_FP;
                r_respCnt  <= '0;
              end else begin
                r_respCnt <= r_respCnt + 1'b1;
              end
            end
            default: begin
              r_state    <= ST_IDLE;
              r_posX     <= INIT_X_FP;
              r_posY     <= INIT_Y_FP;
              r_vx       <= '0;
              r_vy       <= '0;
              r_respCnt  <= '0;
              r_showBird <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign topLeftX = r_posX[FP_BITS +: COORD_W];
  assign topLeftY = r_posY[FP_BITS +: COORD_W];
  assign showBird = r_showBird;
  assign birdHit  = r_birdHit;
  assign stateOut = r_state;

endmodule

// File: tb/tb_bird_flight_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bird_flight_ctrl
// Directed bench for bird_flight_ctrl with default parameters. Each scenario
// task drives its own stimulus and compares against hand-computed values.
// Expected outputs are packed as {stateOut, showBird, topLeftX, topLeftY}.
// ---------------------------------------------------------------------------
module tb_bird_flight_ctrl;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        enable = 1'b0;
  logic        shotCollision = 1'b0;
  logic        borderCollision = 1'b0;
  logic [3:0]  HitEdgeCode = 4'b0;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        showBird;
  logic        birdHit;
  logic [2:0]  stateOut;

  logic [25:0] obs;
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  bird_flight_ctrl dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .enable          (enable),
    .shotCollision   (shotCollision),
    .borderCollision (borderCollision),
    .HitEdgeCode     (HitEdgeCode),
    .topLeftX        (topLeftX),
    .topLeftY        (topLeftY),
    .showBird        (showBird),
    .birdHit         (birdHit),
    .stateOut        (stateOut)
  );

  assign obs = {stateOut, showBird, topLeftX, topLeftY};

  function automatic logic [25:0] view(input logic [2:0] st, input logic sb,
                                       input logic [10:0] x, input logic [10:0] y);
    return {st, sb, x, y};
  endfunction

  // Stimulus helpers: a frame is three quiet cycles then a startOfFrame
  // pulse; they return on the negedge after the tick, when outputs are new.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    idle(3);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic frameWithShot();
    idle(3);
    startOfFrame  = 1'b1;
    shotCollision = 1'b1;
    @(negedge clk);
    startOfFrame  = 1'b0;
    shotCollision = 1'b0;
  endtask

  task automatic pulseBorder(input logic [3:0] code);
    @(negedge clk);
    borderCollision = 1'b1;
    HitEdgeCode     = code;
    @(negedge clk);
    borderCollision = 1'b0;
    HitEdgeCode     = 4'b0;
  endtask

  task automatic pulseShot();
    @(negedge clk);
    shotCollision = 1'b1;
    @(negedge clk);
    shotCollision = 1'b0;
  endtask

  task automatic applyReset();
    @(negedge clk);
    resetN = 1'b0;
    idle(2);
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    resetN = 1'b0;
    idle(2);
    total++;
    if (obs !== view(3'd0, 1'b0, 11'd0, 11'd120))
      $display("[TB] FAIL reset_outputs: got %h want %h", obs, view(3'd0, 1'b0, 11'd0, 11'd120));
    else passed++;
    total++;
    if (birdHit !== 1'b0) $display("[TB] FAIL reset_birdHit: got %b want 0", birdHit);
    else passed++;
    resetN = 1'b1;
    frame();
    total++;
    if (obs !== view(3'd0, 1'b0, 11'd0, 11'd120))
      $display("[TB] FAIL idle_disabled: got %h want %h", obs, view(3'd0, 1'b0, 11'd0, 11'd120));
    else passed++;
  endtask

  task automatic test_fly();
    $display("[TB] test_fly");
    enable = 1'b1;
    frame();
    total++;
    if (obs !== view(3'd1, 1'b1, 11'd0, 11'd120))
      $display("[TB] FAIL fly_start: got %h want %h", obs, view(3'd1, 1'b1, 11'd0, 11'd120));
    else passed++;
    frames(10);
    total++;
    if (obs !== view(3'd1, 1'b1, 11'd10, 11'd125))
      $display("[TB] FAIL fly_10: got %h want %h", obs, view(3'd1, 1'b1, 11'd10, 11'd125));
    else passed++;
  endtask

  task automatic test_bounce();
    $display("[TB] test_bounce");
    pulseBorder(4'b0001);
    frames(2);
    total++;
    if (obs !== view(3'd1, 1'b1, 11'd12, 11'd124))
      $display("[TB] FAIL bounce_bottom: got %h want %h", obs, view(3'd1, 1'b1, 11'd12, 11'd124));
    else passed++;
    pulseBorder(4'b0101);
    frames(2);
    total++;
    if (obs !== view(3'd1, 1'b1, 11'd14, 11'd123))
      $display("[TB] FAIL bounce_both: got %h want %h", obs, view(3'd1, 1'b1, 11'd14, 11'd123));
    else passed++;
    pulseBorder(4'b1010);
    frames(2);
    total++;
    if (obs !== view(3'd1, 1'b1, 11'd16, 11'd122))
      $display("[TB] FAIL bounce_lr: got %h want %h", obs, view(3'd1, 1'b1, 11'd16, 11'd122));
    else passed++;
    pulseBorder(4'b0100);
    frames(2);
    total++;
    if (obs !== view(3'd1, 1'b1, 11'd18, 11'd123))
      $display("[TB] FAIL bounce_top: got %h want %h", obs, view(3'd1, 1'b1, 11'd18, 11'd123));
    else passed++;
  endtask

  task automatic test_wrap();
    $display("[TB] test_wrap");
    applyReset();
    frame();
    frames(639);
    total++;
    if (obs !== view(3'd1, 1'b1, 11'd639, 11'd439))
      $display("[TB] FAIL wrap_before: got %h want %h", obs, view(3'd1, 1'b1, 11'd639, 11'd439));
    else passed++;
    frame();
    total++;
    if (obs !== view(3'd1, 1'b1, 11'd0, 11'd440))
      $display("[TB] FAIL wrap_after: got %h want %h", obs, view(3'd1, 1'b1, 11'd0, 11'd440));
    else passed++;
  endtask

  task automatic test_shot_fall();
    $display("[TB] test_shot_fall");
    applyReset();
    frame();
    frames(2);
    total++;
    if (obs !== view(3'd1, 1'b1, 11'd2, 11'd121))
      $display("[TB] FAIL shot_pre: got %h want %h", obs, view(3'd1, 1'b1, 11'd2, 11'd121));
    else passed++;
    pulseShot();
    frame();
    total++;
    if (obs !== view(3'd2, 1'b1, 11'd2, 11'd121))
      $display("[TB] FAIL shot_fall_entry: got %h want %h", obs, view(3'd2, 1'b1, 11'd2, 11'd121));
    else passed++;
    total++;
    if (birdHit !== 1'b1) $display("[TB] FAIL shot_birdHit_high: got %b want 1", birdHit);
    else passed++;
    @(negedge clk);
    total++;
    if (birdHit !== 1'b0) $display("[TB] FAIL shot_birdHit_low: got %b want 0", birdHit);
    else passed++;
    frames(3);
    total++;
    if (obs !== view(3'd2, 1'b1, 11'd2, 11'd122))
      $display("[TB] FAIL fall_3: got %h want %h", obs, view(3'd2, 1'b1, 11'd2, 11'd122));
    else passed++;
    pulseShot();
    frame();
    total++;
    if (obs !== view(3'd2, 1'b1, 11'd2, 11'd123))
      $display("[TB] FAIL fall_4: got %h want %h", obs, view(3'd2, 1'b1, 11'd2, 11'd123));
    else passed++;
    total++;
    if (birdHit !== 1'b0) $display("[TB] FAIL fall_second_hit: got %b want 0", birdHit);
    else passed++;
    frames(49);
    total++;
    if (obs !== view(3'd2, 1'b1, 11'd2, 11'd478))
      $display("[TB] FAIL fall_53: got %h want %h", obs, view(3'd2, 1'b1, 11'd2, 11'd478));
    else passed++;
    frame();
    total++;
    if ({stateOut, showBird} !== {3'd3, 1'b0})
      $display("[TB] FAIL fall_exit: got %h want %h", {stateOut, showBird}, {3'd3, 1'b0});
    else passed++;
  endtask

  task automatic test_respawn();
    int hidden;
    $display("[TB] test_respawn");
    hidden = 0;
    for (int i = 0; i < 59; i++) begin
      frame();
      if (showBird === 1'b0 && stateOut === 3'd3) hidden++;
    end
    total++;
    if (hidden != 59) $display("[TB] FAIL respawn_hidden: got %0d want 59", hidden);
    else passed++;
    frame();
    total++;
    if (obs !== view(3'd1, 1'b1, 11'd0, 11'd120))
      $display("[TB] FAIL respawn_exit: got %h want %h", obs, view(3'd1, 1'b1, 11'd0, 11'd120));
    else passed++;
    frames(2);
    total++;
    if (obs !== view(3'd1, 1'b1, 11'd2, 11'd121))
      $display("[TB] FAIL respawn_velocity: got %h want %h", obs, view(3'd1, 1'b1, 11'd2, 11'd121));
    else passed++;
  endtask

  task automatic test_shot_and_border();
    $display("[TB] test_shot_and_border");
    applyReset();
    frame();
    frames(2);
    @(negedge clk);
    shotCollision   = 1'b1;
    borderCollision = 1'b1;
    HitEdgeCode     = 4'b0001;
    @(negedge clk);
    shotCollision   = 1'b0;
    borderCollision = 1'b0;
    HitEdgeCode     = 4'b0;
    frame();
    total++;
    if (obs !== view(3'd2, 1'b1, 11'd2, 11'd121))
      $display("[TB] FAIL both_entry: got %h want %h", obs, view(3'd2, 1'b1, 11'd2, 11'd121));
    else passed++;
    total++;
    if (birdHit !== 1'b1) $display("[TB] FAIL both_birdHit: got %b want 1", birdHit);
    else passed++;
  endtask

  task automatic test_sof_collision();
    $display("[TB] test_sof_collision");
    applyReset();
    frame();
    frames(2);
    frameWithShot();
    total++;
    if (obs !== view(3'd1, 1'b1, 11'd3, 11'd121))
      $display("[TB] FAIL sof_shot_deferred: got %h want %h", obs, view(3'd1, 1'b1, 11'd3, 11'd121));
    else passed++;
    frame();
    total++;
    if (obs !== view(3'd2, 1'b1, 11'd3, 11'd121))
      $display("[TB] FAIL sof_shot_applied: got %h want %h", obs, view(3'd2, 1'b1, 11'd3, 11'd121));
    else passed++;
    total++;
    if (birdHit !== 1'b1) $display("[TB] FAIL sof_shot_birdHit: got %b want 1", birdHit);
    else passed++;
  endtask

  task automatic test_reset_in_fall();
    $display("[TB] test_reset_in_fall");
    frame();
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    total++;
    if (obs !== view(3'd0, 1'b0, 11'd0, 11'd120))
      $display("[TB] FAIL async_reset: got %h want %h", obs, view(3'd0, 1'b0, 11'd0, 11'd120));
    else passed++;
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_enable_off();
    $display("[TB] test_enable_off");
    frame();
    frames(3);
    @(negedge clk);
    enable = 1'b0;
    idle(2);
    total++;
    if (obs !== view(3'd1, 1'b1, 11'd3, 11'd121))
      $display("[TB] FAIL enable_off_wait: got %h want %h", obs, view(3'd1, 1'b1, 11'd3, 11'd121));
    else passed++;
    frame();
    total++;
    if (obs !== view(3'd0, 1'b0, 11'd0, 11'd120))
      $display("[TB] FAIL enable_off_idle: got %h want %h", obs, view(3'd0, 1'b0, 11'd0, 11'd120));
    else passed++;
    enable = 1'b1;
    frame();
    total++;
    if (obs !== view(3'd1, 1'b1, 11'd0, 11'd120))
      $display("[TB] FAIL enable_back_on: got %h want %h", obs, view(3'd1, 1'b1, 11'd0, 11'd120));
    else passed++;
  endtask

  initial begin
    test_reset();
    test_fly();
    test_bounce();
    test_wrap();
    test_shot_fall();
    test_respawn();
    test_shot_and_border();
    test_sof_collision();
    test_reset_in_fall();
    test_enable_off();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
